// File: rtl/rom_scan_controller.sv
// rom_scan_controller
// Raster-scan sequencer for the 256x256 image ROM. Walks (col,row) across the
// frame, issues ROM addresses under a credit limit, realigns the returned
// data with its coordinate tag through a latency-matched pipe, and buffers
// pixels in a show-ahead FIFO that feeds a valid/ready stream.
module rom_scan_controller #(
  parameter int WIDTH       = 256,
  parameter int HEIGHT      = 256,
  parameter int ROM_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iStart,
  output logic       oBusy,
  output logic       oDone,
  output logic [7:0] oRomCol,
  output logic [7:0] oRomRow,
  input  logic [7:0] iRomData,
  output logic       oValid,
  input  logic       iReady,
  output logic [7:0] oPixel,
  output logic [7:0] oPixelCol,
  output logic [7:0] oPixelRow,
  output logic       oFirst,
  output logic       oLast
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int CRED_W = CNT_W + 1;

  localparam logic [7:0]        LAST_COL      = 8'(WIDTH - 1);
  localparam logic [7:0]        LAST_ROW      = 8'(HEIGHT - 1);
  localparam logic [CRED_W-1:0] DEPTH_CREDITS = CRED_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR      = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Coordinate tag that travels alongside a ROM read.
  typedef struct packed {
    logic [7:0] col;
    logic [7:0] row;
    logic       first;
    logic       last;
  } tag_t;

  // One buffered output pixel.
  typedef struct packed {
    tag_t       tag;
    logic [7:0] pixel;
  } entry_t;

  state_t state;
  state_t state_next;

  // Address generator.
  logic [7:0] col;
  logic [7:0] row;
  logic       at_last_col;
  logic       at_last_addr;
  logic       is_first_addr;
  logic       issue;

  // Credit accounting: reads in flight plus buffered pixels never exceed depth.
  logic [CNT_W-1:0]  inflight;
  logic [CRED_W-1:0] credits_used;

  // Latency-matched tag pipe.
  logic [ROM_LATENCY-1:0] pipe_valid;
  tag_t                   pipe_tag [ROM_LATENCY];

  // Output FIFO.
  entry_t           fifo_mem [FIFO_DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             push;
  logic             pop;
  logic             not_empty;
  logic             last_pop;

  logic done_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Issue, handshake and address-position decode.
  // NOTE: every signal written in an always_comb gets a value on every path
  // (here, unconditionally) so no latch is inferred.
  always_comb begin
    at_last_col   = (col == LAST_COL);
    at_last_addr  = at_last_col && (row == LAST_ROW);
    is_first_addr = (col == 8'd0) && (row == 8'd0);
    credits_used  = {1'b0, inflight} + {1'b0, fifo_count};
    issue         = (state == S_SCAN) && (credits_used < DEPTH_CREDITS);
    push          = pipe_valid[ROM_LATENCY-1];
    not_empty     = (fifo_count != '0);
    head          = fifo_mem[rd_ptr];
    pop           = not_empty && iReady;
    last_pop      = pop && head.tag.last;
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // FSM next-state logic; iStart only matters in IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (iStart)                state_next = S_SCAN;
      S_SCAN:  if (issue && at_last_addr) state_next = S_DRAIN;
      S_DRAIN: if (last_pop)              state_next = S_IDLE;
      default:                            state_next = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    oBusy = (state != S_IDLE);
    oDone = done_q;
  end

  // Done pulse: one cycle after the handshake of the frame's last pixel.
  always_ff @(posedge clock) begin
    if (!reset_n) done_q <= 1'b0;
    else          done_q <= (state == S_DRAIN) && last_pop;
  end

  // Raster address walk; returns to (0,0) once the final address is issued.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      col <= 8'd0;
      row <= 8'd0;
    end else if (issue) begin
      if (at_last_addr) begin
        col <= 8'd0;
        row <= 8'd0;
      end else if (at_last_col) begin
        col <= 8'd0;
        row <= row + 8'd1;
      end else begin
        col <= col + 8'd1;
      end
    end
  end

  // Tag pipe: delays the issue strobe and its coordinates by ROM_LATENCY.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pipe_valid <= '0;
      for (int k = 0; k < ROM_LATENCY; k++) pipe_tag[k] <= '0;
    end else begin
      pipe_valid[0] <= issue;
      pipe_tag[0]   <= '{col: col, row: row, first: is_first_addr, last: at_last_addr};
      for (int k = 1; k < ROM_LATENCY; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_tag[k]   <= pipe_tag[k-1];
      end
    end
  end

  // Reads in flight: up on issue, down when the data lands in the FIFO.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      inflight <= '0;
    end else begin
      unique case ({issue, push})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // FIFO pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage, written with the ROM data and its realigned tag.
  // NOTE: the storage array is deliberately not reset; the cleared count
  // marks it empty and the outputs are gated while empty.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= '{tag: pipe_tag[ROM_LATENCY-1], pixel: iRomData};
  end

  // Stream outputs from the FIFO head; zero while nothing is buffered.
  always_comb begin
    oValid    = not_empty;
    oPixel    = not_empty ? head.pixel     : 8'd0;
    oPixelCol = not_empty ? head.tag.col   : 8'd0;
    oPixelRow = not_empty ? head.tag.row   : 8'd0;
    oFirst    = not_empty && head.tag.first;
    oLast     = not_empty && head.tag.last;
    oRomCol   = col;
    oRomRow   = row;
  end

endmodule
